// File: rtl/shift_add_multiplier.sv
// Sequential unsigned W x W multiplier: one partial product per cycle, summed through a 16-bit CLA.
// Handshaked operand input and product output; product register holds until the next result.

module cla16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o
);
  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [3:0]  grp_c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_grp
      localparam int B = 4 * gi;
      logic [3:0] c;
      assign grp_g[gi] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                       | (p[B+3] & p[B+2] & p[B+1] & g[B]);
      assign grp_p[gi] = &p[B+3:B];
      assign c[0] = grp_c[gi];
      assign c[1] = g[B] | (p[B] & grp_c[gi]);
      assign c[2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & grp_c[gi]);
      assign c[3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & grp_c[gi]);
      assign sum_o[B+3:B] = p[B+3:B] ^ c;
    end
  endgenerate

  // Second-level lookahead; the final carry-out is never needed since products cannot overflow.
  assign grp_c[0] = cin_i;
  assign grp_c[1] = grp_g[0] | (grp_p[0] & cin_i);
  assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin_i);
  assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[2] & grp_p[1] & grp_p[0] & cin_i);
endmodule

module shift_add_multiplier #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   mcand,
  input  logic [W-1:0]   mplier,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product,
  output logic           busy
);
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           state_q, state_d;
  logic [2*W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*W-1:0]   product_q, product_d;
  logic [2*W-1:0]   addend;
  logic [2*W-1:0]   sum;

  assign addend = mplier_q[cnt_q] ? (mcand_q << cnt_q) : '0;

  cla16 u_cla (
    .a_i   (acc_q),
    .b_i   (addend),
    .cin_i (1'b0),
    .sum_o (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = {{W{1'b0}}, mcand};
          mplier_d = mplier;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
        // Fixed W-cycle latency: no early exit on zero operands.
        if (cnt_q == CW'(W - 1)) begin
          product_d = sum;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == HOLD);
  assign product   = product_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomized self-checking bench for shift_add_multiplier against a plain-arithmetic product model.

module tb_shift_add_multiplier;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  mcand;
  logic [7:0]  mplier;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  shift_add_multiplier #(.W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mcand     (mcand),
    .mplier    (mplier),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int r;
    r = int'(a) * int'(b);
    return r[15:0];
  endfunction

  // Presents one operand pair from IDLE and waits (bounded) for out_valid; lat counts edges after acceptance.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] p, output int lat, output logic busy_after_accept);
    in_valid = 1'b1;
    mcand    = a;
    mplier   = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    busy_after_accept = busy;
    lat = 0;
    while (!out_valid && lat < 20) begin
      mcand  = 8'($urandom);
      mplier = 8'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    p = product;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mcand = '0; mplier = '0;
    #12;
    n_vec++;
    if ({in_ready, busy, out_valid} !== 3'b100 || product !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy/busy/ov=%b product=%h expected 100 product=0000",
               {in_ready, busy, out_valid}, product);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [15:0] p; int lat; logic b0;
    out_ready = 1'b1;
    do_op(8'd13, 8'd11, p, lat, b0);
    n_vec++;
    if (b0 !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b expected 1", b0); end
    n_vec++;
    if (lat !== 8) begin n_bad++; $display("FAIL basic_latency: got %0d expected 8", lat); end
    n_vec++;
    if (p !== 16'h008F) begin n_bad++; $display("FAIL basic_product: got %h expected 008f", p); end
    @(posedge clk); #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_return_idle: got rdy=%b ov=%b expected rdy=1 ov=0", in_ready, out_valid);
    end
    $display("basic 13*11 -> %h latency %0d", p, lat);
  endtask

  task automatic test_corners();
    logic [15:0] p; int lat; logic b0;
    logic [7:0] ca[3] = '{8'd255, 8'd0, 8'd1};
    logic [7:0] cb[3] = '{8'd255, 8'd200, 8'd0};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_op(ca[i], cb[i], p, lat, b0);
      n_vec++;
      if (p !== ref_mul(ca[i], cb[i]) || lat !== 8) begin
        n_bad++;
        $display("FAIL corner_%0d: got product=%h lat=%0d expected product=%h lat=8",
                 i, p, lat, ref_mul(ca[i], cb[i]));
      end
      @(posedge clk); #1;
      $display("corner %0d*%0d -> %h latency %0d", ca[i], cb[i], p, lat);
    end
  endtask

  task automatic test_hold_stall();
    logic [15:0] p; int lat; logic b0;
    out_ready = 1'b0;
    do_op(8'd13, 8'd11, p, lat, b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom);
      mcand    = 8'($urandom);
      mplier   = 8'($urandom);
      @(posedge clk); #1;
      n_vec++;
      if (product !== 16'h008F || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_stall_%0d: got product=%h ov=%b rdy=%b expected 008f 1 0",
                 i, product, out_valid, in_ready);
      end
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_release: got rdy=%b busy=%b ov=%b expected 1 0 0", in_ready, busy, out_valid);
    end
    $display("hold stall 5 cycles, product %h released", p);
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] p; int lat; logic b0;
    out_ready = 1'b1;
    in_valid = 1'b1; mcand = 8'd200; mplier = 8'd77;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_vec++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL midrun_busy: got %b expected 1", busy); end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({in_ready, busy, out_valid} !== 3'b100 || product !== 16'h0000) begin
      n_bad++;
      $display("FAIL midrun_reset: got rdy/busy/ov=%b product=%h expected 100 0000",
               {in_ready, busy, out_valid}, product);
    end
    @(negedge clk); rst_n = 1'b1;
    do_op(8'd3, 8'd5, p, lat, b0);
    n_vec++;
    if (p !== 16'h000F || lat !== 8) begin
      n_bad++; $display("FAIL post_reset_op: got product=%h lat=%0d expected 000f lat=8", p, lat);
    end
    @(posedge clk); #1;
    $display("reset mid-run, then 3*5 -> %h latency %0d", p, lat);
  endtask

  task automatic test_back_to_back();
    logic [7:0]  pa[3];
    logic [7:0]  pb[3];
    int          acc_cyc[3];
    logic [15:0] expq[$];
    int          n_acc = 0;
    int          n_out = 0;
    int          cyc = 0;
    for (int i = 0; i < 3; i++) begin
      pa[i] = 8'($urandom_range(1, 255));
      pb[i] = 8'($urandom_range(1, 255));
      acc_cyc[i] = 0;
    end
    out_ready = 1'b1;
    while (n_out < 3 && cyc < 100) begin
      if (out_valid) begin
        n_vec++;
        if (expq.size() == 0) begin
          n_bad++; $display("FAIL b2b_unexpected: got product=%h with no operation pending", product);
        end else begin
          if (product !== expq[0]) begin
            n_bad++; $display("FAIL b2b_product_%0d: got %h expected %h", n_out, product, expq[0]);
          end
          $display("b2b result %0d -> %h", n_out, product);
          void'(expq.pop_front());
        end
        n_out++;
      end
      if (in_ready && n_acc < 3) begin
        in_valid = 1'b1;
        mcand    = pa[n_acc];
        mplier   = pb[n_acc];
        expq.push_back(ref_mul(pa[n_acc], pb[n_acc]));
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end else begin
        in_valid = (n_acc < 3);
        mcand    = 8'($urandom);
        mplier   = 8'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    n_vec++;
    if (n_out < 3) begin n_bad++; $display("FAIL b2b_timeout: got %0d products expected 3", n_out); end
    for (int i = 1; i < 3; i++) begin
      n_vec++;
      if (acc_cyc[i] - acc_cyc[i-1] !== 10) begin
        n_bad++; $display("FAIL b2b_spacing_%0d: got %0d cycles expected 10", i, acc_cyc[i] - acc_cyc[i-1]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] p; int lat; logic b0;
    logic [7:0] a, b;
    int stall;
    int bad_before;
    bad_before = n_bad;
    for (int k = 0; k < 1000; k++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      stall = $urandom_range(0, 2);
      out_ready = (stall == 0);
      do_op(a, b, p, lat, b0);
      n_vec++;
      if (p !== ref_mul(a, b) || lat !== 8) begin
        n_bad++;
        $display("FAIL random_%0d: %0d*%0d got product=%h lat=%0d expected %h lat=8",
                 k, a, b, p, lat, ref_mul(a, b));
      end
      repeat (stall) begin @(posedge clk); #1; end
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
    $display("random sweep: 1000 pairs, %0d miscompared", n_bad - bad_before);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_hold_stall();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 SHALL have parameter W, default 8, operand width; only W=8 is supported because the product width 2W must equal the 16-bit carry-lookahead adder width.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, operand pair present.
REQ-005 SHALL have port in_ready, output, 1, block can accept operands.
REQ-006 SHALL have port mcand, input, W, unsigned multiplicand.
REQ-007 SHALL have port mplier, input, W, unsigned multiplier.
REQ-008 SHALL have port out_valid, output, 1, product available.
REQ-009 SHALL have port out_ready, input, 1, consumer takes product.
REQ-010 SHALL have port product, output, 2W, unsigned product.
REQ-011 SHALL have port busy, output, 1, high while in RUN.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, HOLD; the reset state is IDLE.
REQ-013 SHALL drive in_ready=1 only in IDLE, busy=1 only in RUN, and out_valid=1 only in HOLD; these outputs are decoded from registered state.
REQ-014 SHALL accept operands on an edge with IDLE and in_valid=1: latch mcand zero-extended to 2W bits, latch mplier, clear the accumulator to 0, clear the bit counter to 0, and go to RUN.
REQ-015 SHALL, on each RUN edge with counter i, load the accumulator with acc + (mplier[i] ? mcand<<i : 0) mod 2^(2W).
REQ-016 SHALL form that sum with one instance of the team's 16-bit carry-lookahead adder: A=acc, B=gated shifted multiplicand, Cin=0.
REQ-017 SHALL take exactly W RUN edges; on the edge processing i=W-1, copy the new accumulator value to product and go to HOLD. Latency is fixed at W cycles from acceptance to out_valid, independent of operand values; there are no zero-operand shortcuts.
REQ-018 SHALL hold product constant from entry to HOLD until the next entry to HOLD; product does not change during RUN.
REQ-019 SHALL stay in HOLD while out_ready=0; product and out_valid stay stable.
REQ-020 SHALL, on a HOLD edge with out_ready=1, go to IDLE; operands are not accepted on that same edge.
REQ-021 SHALL ignore in_valid and operand changes while in RUN or HOLD.
REQ-022 SHALL ignore out_ready outside HOLD.
REQ-023 SHALL provide a sustained throughput of one product per W+2 cycles when in_valid=1 and out_ready=1 are held high.
REQ-024 SHALL never overflow the accumulator, since (2^W-1)^2 < 2^(2W); no carry-out is observed.

Reset
REQ-025 SHALL, while rst_n=0, immediately and asynchronously force state=IDLE, product=0, accumulator=0, counter=0, and latched operands=0; this gives in_ready=1, out_valid=0, busy=0.
REQ-026 SHALL, on reset asserted mid-RUN or mid-HOLD, discard the in-flight operation with no partial product emitted.
REQ-027 SHALL accept new operands on the first rising edge after rst_n deasserts if in_valid=1.

Verification
REQ-028 SHALL cover: mcand=13, mplier=11, out_ready=1 -> out_valid rises exactly 8 cycles after acceptance, product=0x008F, then in_ready=1 the next cycle.
REQ-029 SHALL cover: 255*255 -> product=0xFE01; also 0*200 -> product=0x0000 with unchanged 8-cycle latency.
REQ-030 SHALL cover: out_ready=0 for 5 cycles in HOLD, with new in_valid/operands toggling -> product stays 0x008F, out_valid stays 1, in_ready stays 0; on out_ready=1, return to IDLE.
REQ-031 SHALL cover: rst_n pulsed low during the 4th RUN cycle -> in_ready=1, busy=0, out_valid=0, product=0 immediately; a following 3*5 yields 0x000F.
REQ-032 SHALL cover: back-to-back in_valid=1, out_ready=1 with 3 operand pairs -> products in order, successive acceptances 10 cycles apart.
REQ-033 SHALL cover: random sweep of 1000 operand pairs compared against a W x W reference model, with no mismatches.
